// File: rtl/mmio_regbank.sv
// MMIO register bank: output regs, synchronised input levels, sticky rising-edge flags.
// Define IO_DEBOUNCE_EN to add a per-pin stable-count debouncer after the synchroniser.
module mmio_regbank #(
    parameter int          NUM_OUT   = 4,
    parameter int          OUT_W     = 8,
    parameter logic [31:0] OUT_RESET = '0,
    parameter int          IN_W      = 4,
    parameter int          DB_CYC    = 1000
) (
    input  logic                     CLK,
    input  logic                     reset,
    input  logic                     sel,
    input  logic [4:0]               word_addr,
    input  logic [31:0]              wdata,
    input  logic [3:0]               wmask,
    input  logic                     rstrb,
    output logic [31:0]              rdata,
    output logic                     rbusy,
    output logic [NUM_OUT*OUT_W-1:0] out_data,
    input  logic [IN_W-1:0]          in_pins
);

    localparam logic [4:0] IDX_LVL  = 5'(NUM_OUT);
    localparam logic [4:0] IDX_EDGE = 5'(NUM_OUT + 1);

    logic [31:0]      lane_mask;
    logic             wr;
    logic             rd;
    logic [OUT_W-1:0] out_q [NUM_OUT];
    logic [IN_W-1:0]  sync1;
    logic [IN_W-1:0]  sync2;
    logic [IN_W-1:0]  lvl;
    logic [IN_W-1:0]  lvl_q;
    logic [IN_W-1:0]  edge_flags;
    logic [IN_W-1:0]  rise;
    logic [IN_W-1:0]  clr;
    logic [31:0]      rd_val;
    logic             unused_bits;

    always_comb begin
        for (int b = 0; b < 4; b++) begin
            lane_mask[8*b +: 8] = {8{wmask[b]}};
        end
    end

    // A write strobe always suppresses a read issued in the same cycle.
    assign wr = sel & (|wmask);
    assign rd = sel & rstrb & ~(|wmask);

    always_ff @(posedge CLK) begin
        if (reset) begin
            for (int k = 0; k < NUM_OUT; k++) begin
                out_q[k] <= OUT_RESET[OUT_W-1:0];
            end
        end else begin
            for (int k = 0; k < NUM_OUT; k++) begin
                if (wr && word_addr == 5'(k)) begin
                    out_q[k] <= (out_q[k] & ~lane_mask[OUT_W-1:0])
                              | (wdata[OUT_W-1:0] & lane_mask[OUT_W-1:0]);
                end
            end
        end
    end

    for (genvar k = 0; k < NUM_OUT; k++) begin : g_out
        assign out_data[k*OUT_W +: OUT_W] = out_q[k];
    end

    always_ff @(posedge CLK) begin
        if (reset) begin
            sync1 <= '0;
            sync2 <= '0;
            lvl_q <= '0;
        end else begin
            sync1 <= in_pins;
            sync2 <= sync1;
            lvl_q <= lvl;
        end
    end

`ifdef IO_DEBOUNCE_EN
    localparam int CW = $clog2(DB_CYC + 1);

    logic [CW-1:0]   cnt [IN_W];
    logic [IN_W-1:0] lvl_reg;

    // lvl follows sync2 only after it has disagreed for DB_CYC straight cycles.
    always_ff @(posedge CLK) begin
        if (reset) begin
            lvl_reg <= '0;
            for (int i = 0; i < IN_W; i++) begin
                cnt[i] <= '0;
            end
        end else begin
            for (int i = 0; i < IN_W; i++) begin
                if (sync2[i] == lvl_reg[i]) begin
                    cnt[i] <= '0;
                end else if (cnt[i] == CW'(DB_CYC - 1)) begin
                    lvl_reg[i] <= sync2[i];
                    cnt[i]     <= '0;
                end else begin
                    cnt[i] <= cnt[i] + CW'(1);
                end
            end
        end
    end

    assign lvl = lvl_reg;
`else
    assign lvl = sync2;
`endif

    assign rise = lvl & ~lvl_q;
    assign clr  = (wr && word_addr == IDX_EDGE)
                ? (wdata[IN_W-1:0] & lane_mask[IN_W-1:0])
                : '0;

    // A new edge in the same cycle as its W1C keeps the flag set.
    always_ff @(posedge CLK) begin
        if (reset) begin
            edge_flags <= '0;
        end else begin
            edge_flags <= (edge_flags & ~clr) | rise;
        end
    end

    always_comb begin
        rd_val = '0;
        for (int k = 0; k < NUM_OUT; k++) begin
            if (word_addr == 5'(k)) begin
                rd_val[OUT_W-1:0] = out_q[k];
            end
        end
        if (word_addr == IDX_LVL) begin
            rd_val[IN_W-1:0] = lvl;
        end
        if (word_addr == IDX_EDGE) begin
            rd_val[IN_W-1:0] = edge_flags;
        end
    end

    always_ff @(posedge CLK) begin
        if (reset) begin
            rdata <= '0;
            rbusy <= 1'b0;
        end else begin
            rbusy <= rd;
            if (rd) begin
                rdata <= rd_val;
            end
        end
    end

    assign unused_bits = ^{wdata, lane_mask, 32'(DB_CYC)};

endmodule

// File: tb/tb_mmio_regbank.sv
// Scoreboard bench for mmio_regbank: directed scenarios then randomized bus and pin traffic.
// Build with IO_DEBOUNCE_EN defined to exercise the debounce path (DB_CYC=8).
module tb_mmio_regbank;

    localparam int          NUM_OUT   = 4;
    localparam int          OUT_W     = 8;
    localparam logic [31:0] OUT_RESET = 32'h84;
    localparam int          IN_W      = 4;
    localparam int          DB_CYC    = 8;

    logic                     CLK = 1'b0;
    logic                     reset;
    logic                     sel;
    logic [4:0]               word_addr;
    logic [31:0]              wdata;
    logic [3:0]               wmask;
    logic                     rstrb;
    logic [31:0]              rdata;
    logic                     rbusy;
    logic [NUM_OUT*OUT_W-1:0] out_data;
    logic [IN_W-1:0]          in_pins;

    int compared   = 0;
    int mismatched = 0;

    mmio_regbank #(
        .NUM_OUT  (NUM_OUT),
        .OUT_W    (OUT_W),
        .OUT_RESET(OUT_RESET),
        .IN_W     (IN_W),
        .DB_CYC   (DB_CYC)
    ) dut (
        .CLK      (CLK),
        .reset    (reset),
        .sel      (sel),
        .word_addr(word_addr),
        .wdata    (wdata),
        .wmask    (wmask),
        .rstrb    (rstrb),
        .rdata    (rdata),
        .rbusy    (rbusy),
        .out_data (out_data),
        .in_pins  (in_pins)
    );

    always #5 CLK = ~CLK;

    // Reference model state
    logic [OUT_W-1:0] m_out [NUM_OUT];
    logic [IN_W-1:0]  m_edge;
    logic [IN_W-1:0]  m_lvl;
    logic [IN_W-1:0]  m_lvl_old;
    logic [IN_W-1:0]  pin_d1;
    logic [IN_W-1:0]  pin_d2;
    int               run [IN_W];
    logic [31:0]      m_rdata;
    logic [31:0]      exp_q [$];

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] model_read(input logic [4:0] idx);
        logic [31:0] v;
        v = '0;
        if (idx < NUM_OUT) v[OUT_W-1:0] = m_out[idx];
        else if (idx == NUM_OUT) v[IN_W-1:0] = m_lvl;
        else if (idx == NUM_OUT + 1) v[IN_W-1:0] = m_edge;
        return v;
    endfunction

    always @(posedge CLK) begin
        logic [IN_W-1:0] rise;
        if (reset) begin
            for (int k = 0; k < NUM_OUT; k++) m_out[k] = OUT_RESET[OUT_W-1:0];
            for (int i = 0; i < IN_W; i++) run[i] = 0;
            m_edge = '0; m_lvl = '0; m_lvl_old = '0;
            pin_d1 = '0; pin_d2 = '0; m_rdata = '0;
            exp_q.delete();
        end else begin
            if (sel && rstrb && wmask == 4'b0) begin
                m_rdata = model_read(word_addr);
                exp_q.push_back(m_rdata);
            end
            rise = m_lvl & ~m_lvl_old;
            if (sel && wmask != 4'b0) begin
                if (word_addr < NUM_OUT) begin
                    for (int j = 0; j < OUT_W; j++)
                        if (wmask[j/8]) m_out[word_addr][j] = wdata[j];
                end else if (word_addr == NUM_OUT + 1) begin
                    for (int i = 0; i < IN_W; i++)
                        if (wdata[i] && wmask[i/8]) m_edge[i] = 1'b0;
                end
            end
            m_edge = m_edge | rise;
            m_lvl_old = m_lvl;
`ifdef IO_DEBOUNCE_EN
            for (int i = 0; i < IN_W; i++) begin
                if (pin_d2[i] == m_lvl[i]) run[i] = 0;
                else begin
                    run[i]++;
                    if (run[i] == DB_CYC) begin
                        m_lvl[i] = pin_d2[i];
                        run[i] = 0;
                    end
                end
            end
`else
            m_lvl = pin_d1;
`endif
            pin_d2 = pin_d1;
            pin_d1 = in_pins;
        end
    end

    // Monitor: continuous output checks plus read-response scoreboard
    always @(negedge CLK) begin
        logic [NUM_OUT*OUT_W-1:0] exp_out;
        logic [31:0] e;
        for (int k = 0; k < NUM_OUT; k++) exp_out[k*OUT_W +: OUT_W] = m_out[k];
        chk("out_data", out_data, exp_out);
        chk("rdata_hold", rdata, m_rdata);
        if (rbusy === 1'b1) begin
            if (exp_q.size() == 0) begin
                chk("rbusy_spurious", rbusy, 1'b0);
            end else begin
                e = exp_q.pop_front();
                chk("read_resp", rdata, e);
            end
        end
    end

    task automatic drive(input logic s, input logic [4:0] a, input logic [31:0] d,
                         input logic [3:0] m, input logic r);
        sel = s; word_addr = a; wdata = d; wmask = m; rstrb = r;
        @(negedge CLK);
    endtask

    task automatic idle(input int n);
        repeat (n) drive(1'b0, 5'd0, 32'd0, 4'd0, 1'b0);
    endtask

    initial begin
        reset = 1'b1; in_pins = '0;
        sel = 1'b0; word_addr = '0; wdata = '0; wmask = '0; rstrb = 1'b0;
        @(negedge CLK); @(negedge CLK);
        chk("reset_out", out_data, 32'h8484_8484);
        chk("reset_rdata", rdata, 32'h0);
        chk("reset_rbusy", rbusy, 1'b0);
        reset = 1'b0;

        drive(1'b1, 5'd1, 32'hA5C3_1234, 4'b0001, 1'b0);
        chk("wr_lane0", out_data[15:8], 8'h34);
        drive(1'b1, 5'd1, 32'hFFFF_FFFF, 4'b0010, 1'b0);
        chk("wr_lane1_ignored", out_data[15:8], 8'h34);
        drive(1'b1, 5'd20, 32'h0, 4'b1111, 1'b0);
        chk("wr_unmapped", out_data, 32'h8484_3484);
        drive(1'b1, 5'd4, 32'h0, 4'b1111, 1'b0);
        chk("wr_in_lvl", out_data, 32'h8484_3484);

`ifndef IO_DEBOUNCE_EN
        in_pins = 4'b1010;
        idle(3);
        drive(1'b1, 5'd4, 32'h0, 4'b0000, 1'b1);
        chk("in_lvl_read", rdata, 32'h0000_000A);
        chk("rbusy_high", rbusy, 1'b1);
        idle(1);
        chk("rbusy_pulse", rbusy, 1'b0);

        drive(1'b1, 5'd5, 32'hF, 4'b0001, 1'b0);
        in_pins = 4'b1011;
        idle(4);
        drive(1'b1, 5'd5, 32'h0, 4'b0000, 1'b1);
        chk("edge_pin0", rdata, 32'h1);
        in_pins = 4'b1111;
        idle(2);
        drive(1'b1, 5'd5, 32'h1, 4'b0001, 1'b0);
        drive(1'b1, 5'd5, 32'h0, 4'b0000, 1'b1);
        chk("w1c_with_pin2", rdata, 32'h4);
        drive(1'b1, 5'd5, 32'h4, 4'b0001, 1'b0);
        drive(1'b1, 5'd5, 32'h0, 4'b0000, 1'b1);
        chk("w1c_clear", rdata, 32'h0);

        in_pins = 4'b1110;
        idle(4);
        in_pins = 4'b1111;
        idle(2);
        drive(1'b1, 5'd5, 32'h1, 4'b0001, 1'b0);
        drive(1'b1, 5'd5, 32'h0, 4'b0000, 1'b1);
        chk("set_beats_w1c", rdata, 32'h1);
        drive(1'b1, 5'd0, 32'h5A, 4'b0001, 1'b1);
        chk("rd_wr_rdata", rdata, 32'h1);
        chk("rd_wr_rbusy", rbusy, 1'b0);
        chk("rd_wr_out0", out_data[7:0], 8'h5A);
        drive(1'b1, 5'd31, 32'h0, 4'b0000, 1'b1);
        chk("unmapped_read", rdata, 32'h0);
`else
        drive(1'b1, 5'd5, 32'hF, 4'b0001, 1'b0);
        in_pins = 4'b0001;
        idle(5);
        in_pins = 4'b0000;
        idle(15);
        drive(1'b1, 5'd4, 32'h0, 4'b0000, 1'b1);
        chk("glitch_lvl", rdata, 32'h0);
        drive(1'b1, 5'd5, 32'h0, 4'b0000, 1'b1);
        chk("glitch_edge", rdata, 32'h0);
        in_pins = 4'b0001;
        idle(9);
        drive(1'b1, 5'd4, 32'h0, 4'b0000, 1'b1);
        chk("db_not_yet", rdata, 32'h0);
        drive(1'b1, 5'd4, 32'h0, 4'b0000, 1'b1);
        chk("db_settled", rdata, 32'h1);
        in_pins = 4'b0000;
        idle(3);
        reset = 1'b1;
        idle(1);
        reset = 1'b0;
        drive(1'b1, 5'd4, 32'h0, 4'b0000, 1'b1);
        chk("db_reset_lvl", rdata, 32'h0);
`endif

        for (int n = 0; n < 3000; n++) begin
            logic [4:0] a;
            logic [3:0] m;
            reset = ($urandom_range(0, 299) == 0);
`ifdef IO_DEBOUNCE_EN
            if ($urandom_range(0, 11) == 0) in_pins = IN_W'($urandom);
`else
            if ($urandom_range(0, 5) == 0) in_pins = IN_W'($urandom);
`endif
            a = ($urandom_range(0, 7) == 0) ? 5'($urandom)
                                             : 5'($urandom_range(0, NUM_OUT + 2));
            m = ($urandom_range(0, 1) == 0) ? 4'b0 : 4'($urandom);
            drive($urandom_range(0, 3) != 0, a, $urandom, m, 1'($urandom));
        end

        reset = 1'b0;
        idle(3);
        chk("queue_drain", 64'(exp_q.size()), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
